// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: blank pattern,
// hex decoder and scan state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_sync_rise_det.sv
// Synchroniser for the divided scan clock plus a rising-edge detector that
// yields a single-cycle tick per scan-clock rise.
module sync_rise_det (
    input  logic CLK_IN,
    input  logic clr,
    input  logic async_i,
    output logic tick_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge CLK_IN or posedge clr) begin
        if (clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tick_o = s2_q & ~s3_q;

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment driver: double-buffered hex value, per-digit blank
// interval against ghosting. Optional leading-zero suppression: SEG7_LZ_BLANK_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int BLANK_CYC = 2
) (
    input  logic                  CLK_IN,
    input  logic                  clr,
    input  logic                  scan_clk,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(BLANK_CYC + 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

    scan_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, fd_q;
    logic [4*N_DIGITS-1:0] stage_dig_q, shad_dig_q;
    logic [N_DIGITS-1:0]   stage_dp_q, shad_dp_q;
    logic                  pend_q;
    logic                  tick, boundary;
    logic [3:0]            nib_cur;

    sync_rise_det u_sync (
        .CLK_IN  (CLK_IN),
        .clr     (clr),
        .async_i (scan_clk),
        .tick_o  (tick)
    );

    assign boundary = tick & (idx_q == IDX_LAST);
    assign idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    assign nib_cur  = shad_dig_q[4*idx_q +: 4];

`ifdef SEG7_LZ_BLANK_EN
    logic [IDX_W-1:0] top_nz;

    // Digit 0 is never suppressed, so the search starts at digit 1.
    always_comb begin
        top_nz = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (shad_dig_q[4*i +: 4] != 4'h0) top_nz = IDX_W'(i);
        end
    end

    assign seg_d = (idx_q > top_nz) ? SEG_BLANK : seg7_decode(nib_cur);
`else
    assign seg_d = seg7_decode(nib_cur);
`endif

    always_ff @(posedge CLK_IN or posedge clr) begin
        if (clr) begin
            state_q <= ST_BLANK;
            cnt_q   <= CNT_LOAD;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            fd_q <= boundary;
            if (tick) begin
                idx_q   <= idx_d;
                state_q <= ST_BLANK;
                cnt_q   <= CNT_LOAD;
                an_q    <= '1;
            end else begin
                case (state_q)
                    ST_BLANK: begin
                        an_q <= '1;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_SHOW;
                            an_q    <= ~(AN_ONE << idx_q);
                            seg_q   <= seg_d;
                            dp_q    <= ~shad_dp_q[idx_q];
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        seg_q <= seg_d;
                        dp_q  <= ~shad_dp_q[idx_q];
                    end
                    default: state_q <= ST_BLANK;
                endcase
            end
        end
    end

    // A load landing on the frame boundary bypasses staging straight into the shadow.
    always_ff @(posedge CLK_IN or posedge clr) begin
        if (clr) begin
            stage_dig_q <= '0;
            stage_dp_q  <= '0;
            shad_dig_q  <= '0;
            shad_dp_q   <= '0;
            pend_q      <= 1'b0;
        end else begin
            if (load) begin
                stage_dig_q <= digits_in;
                stage_dp_q  <= dp_in;
            end
            if (boundary) begin
                pend_q <= 1'b0;
                if (load) begin
                    shad_dig_q <= digits_in;
                    shad_dp_q  <= dp_in;
                end else if (pend_q) begin
                    shad_dig_q <= stage_dig_q;
                    shad_dp_q  <= stage_dp_q;
                end
            end else if (load) begin
                pend_q <= 1'b1;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: timeline model of the display checked
// every cycle, plus directed literal expectations.
module tb_seg7_scan;

    localparam int N     = 4;
    localparam int BLANK = 2;

    logic        CLK_IN = 1'b0;
    logic        clr = 1'b1;
    logic        scan_clk = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg7_scan #(.N_DIGITS(N), .BLANK_CYC(BLANK)) dut (
        .CLK_IN     (CLK_IN),
        .clr        (clr),
        .scan_clk   (scan_clk),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: time since last tick, current digit, shadow/staging contents.
    int          m_idx, m_since;
    logic [15:0] m_shad, m_stage;
    logic [3:0]  m_sdp, m_stdp;
    bit          m_pend, m_fd, m_r1, m_r2, m_prev;

    task automatic model_reset();
        m_idx = 0; m_since = 1;
        m_shad = '0; m_stage = '0; m_sdp = '0; m_stdp = '0;
        m_pend = 0; m_fd = 0; m_r1 = 0; m_r2 = 0; m_prev = 0;
    endtask

    task automatic model_step();
        bit tick, bnd;
        tick   = m_r2;
        m_r2   = m_r1;
        m_r1   = scan_clk & ~m_prev;
        m_prev = scan_clk;
        bnd    = tick && (m_idx == N - 1);
        m_fd   = bnd;
        if (bnd) begin
            if (load) begin m_shad = digits_in; m_sdp = dp_in; end
            else if (m_pend) begin m_shad = m_stage; m_sdp = m_stdp; end
            m_pend = 0;
        end else if (load) begin
            m_pend = 1;
        end
        if (load) begin m_stage = digits_in; m_stdp = dp_in; end
        if (tick) begin
            m_idx   = (m_idx + 1) % N;
            m_since = 1;
        end else if (m_since <= BLANK) begin
            m_since++;
        end
    endtask

    function automatic logic [6:0] m_seg();
        logic [3:0] nib;
        int top;
        nib = m_shad[4*m_idx +: 4];
        top = 0;
`ifdef SEG7_LZ_BLANK_EN
        for (int i = 0; i < N; i++) if (m_shad[4*i +: 4] != 4'h0) top = i;
        if (m_idx > top) return 7'h7F;
`endif
        return HEX[nib];
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK_IN or posedge clr);
            if (clr) model_reset();
            else model_step();
        end
    end

    always @(negedge CLK_IN) begin
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp, exp_fd;
        bit         showing;
        showing = (m_since > BLANK);
        exp_an  = showing ? ~(4'b0001 << m_idx) : 4'hF;
        exp_fd  = m_fd;
        chk("an", an, exp_an);
        chk("frame_done", frame_done, exp_fd);
        if (showing) begin
            exp_seg = m_seg();
            exp_dp  = ~m_sdp[m_idx];
            chk("seg", seg, exp_seg);
            chk("dp", dp, exp_dp);
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        load = 1'b1; digits_in = d; dp_in = p;
        @(negedge CLK_IN);
        load = 1'b0;
        @(negedge CLK_IN);
    endtask

    // Called at a negedge; optional load lands on the cycle the tick acts.
    task automatic scan_rise(input bit ld, input logic [15:0] d, input logic [3:0] p);
        scan_clk = 1'b1;
        repeat (2) @(negedge CLK_IN);
        if (ld) begin load = 1'b1; digits_in = d; dp_in = p; end
        @(negedge CLK_IN);
        load = 1'b0;
        scan_clk = 1'b0;
        repeat (6) @(negedge CLK_IN);
    endtask

    task automatic reset_pulse_check(input string tag);
        #2 clr = 1'b1;
        #1;
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"}, dp, 1'b1);
        chk({tag, "_fd"}, frame_done, 1'b0);
        @(negedge CLK_IN);
        #2 clr = 1'b0;
        @(negedge CLK_IN);
    endtask

    initial begin
        int  hc;
        bit  fast;
        logic [15:0] mask;
        logic [6:0]  lz_seg;
`ifdef SEG7_LZ_BLANK_EN
        lz_seg = 7'h7F;
`else
        lz_seg = 7'h40;
`endif
        repeat (3) @(negedge CLK_IN);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        #2 clr = 1'b0;
        repeat (4) @(negedge CLK_IN);

        do_load(16'h1234, 4'h0);
        repeat (4) scan_rise(1'b0, '0, '0);
        chk("d0_1234_an", an, 4'b1110);
        chk("d0_1234_seg", seg, 7'h19);
        scan_rise(1'b0, '0, '0);
        chk("d1_1234_an", an, 4'b1101);
        chk("d1_1234_seg", seg, 7'h30);

        do_load(16'hAAAA, 4'h0);
        do_load(16'h5555, 4'h0);
        repeat (3) scan_rise(1'b0, '0, '0);
        chk("last_load_an", an, 4'b1110);
        chk("last_load_seg", seg, 7'h12);

        repeat (3) scan_rise(1'b0, '0, '0);
        scan_rise(1'b1, 16'h0070, 4'b0001);
        chk("wrap_load_an", an, 4'b1110);
        chk("wrap_load_seg", seg, 7'h40);
        chk("wrap_load_dp", dp, 1'b0);
        scan_rise(1'b0, '0, '0);
        chk("d1_0070_seg", seg, 7'h78);
        chk("d1_0070_dp", dp, 1'b1);
        scan_rise(1'b0, '0, '0);
        chk("d2_0070_seg", seg, lz_seg);
        scan_rise(1'b0, '0, '0);
        chk("d3_0070_an", an, 4'b0111);
        chk("d3_0070_seg", seg, lz_seg);

        scan_clk = 1'b1; @(negedge CLK_IN);
        scan_clk = 1'b0; @(negedge CLK_IN);
        scan_clk = 1'b1; @(negedge CLK_IN);
        scan_clk = 1'b0;
        repeat (10) @(negedge CLK_IN);
        chk("blank_retick_an", an, 4'b1101);
        chk("blank_retick_seg", seg, 7'h78);

        reset_pulse_check("rst_mid_show");
        repeat (4) @(negedge CLK_IN);
        chk("post_rst_an", an, 4'b1110);
        chk("post_rst_seg", seg, 7'h40);

        hc = 0;
        fast = 0;
        for (int c = 0; c < 16000; c++) begin
            @(negedge CLK_IN);
            if (c % 2000 == 0) fast = ($urandom_range(0, 1) == 1);
            if (hc == 0) begin
                scan_clk = ~scan_clk;
                hc = fast ? int'($urandom_range(0, 4)) : 100;
            end else begin
                hc--;
            end
            load = ($urandom_range(0, 24) == 0);
            if (load) begin
                case ($urandom_range(0, 3))
                    0: mask = 16'hFFFF;
                    1: mask = 16'h0FFF;
                    2: mask = 16'h00FF;
                    default: mask = 16'h000F;
                endcase
                digits_in = 16'($urandom) & mask;
                dp_in = 4'($urandom);
            end
            if (c % 5000 == 4999) begin
                load = 1'b0;
                reset_pulse_check("rst_random");
            end
        end
        load = 1'b0;
        repeat (4) @(negedge CLK_IN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
